// File: rtl/card_pkg.sv
// Shared constants, state encoding and helpers for the card-map slot editor.
package card_pkg;

  localparam int unsigned NUM_COLS  = 18;
  localparam int unsigned NUM_ROWS  = 8;
  localparam int unsigned NUM_SLOTS = NUM_COLS * NUM_ROWS;
  localparam int unsigned CODE_W    = 6;
  localparam int unsigned MAP_W     = NUM_SLOTS * CODE_W;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned COL_W   = 5;
  localparam int unsigned ROW_W   = 3;
  localparam int unsigned BIT_W   = 10;

  localparam int unsigned MAP_X0 = 32;
  localparam int unsigned MAP_Y0 = 80;
  localparam int unsigned CARD_W = 32;
  localparam int unsigned CARD_H = 40;

  localparam logic [CODE_W-1:0] EMPTY_CODE = 6'd54;
  localparam logic [MAP_W-1:0]  EMPTY_MAP  = {NUM_SLOTS{EMPTY_CODE}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  // Bit offset of a slot's code inside the flat map vector.
  function automatic logic [BIT_W-1:0] slot_lsb(input logic [IDX_W-1:0] idx);
    return BIT_W'(idx) * BIT_W'(CODE_W);
  endfunction

endpackage

// File: rtl/slot_locator.sv
// Range-checks a grid-relative click offset and converts it to a slot index
// by repeated subtraction of the slot size on both axes in parallel.
module slot_locator
  import card_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [COORD_W-1:0] dx_i,
  input  logic [COORD_W-1:0] dy_i,
  output logic               in_grid_c,
  output logic               done_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic [COORD_W-1:0] rem_x_q, rem_x_d;
  logic [COORD_W-1:0] rem_y_q, rem_y_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               active_q, active_d;
  logic               x_step_c, y_step_c;

  // Offsets left of / above the grid wrap to large values, so one compare per axis suffices.
  assign in_grid_c = (dx_i < COORD_W'(NUM_COLS * CARD_W)) &&
                     (dy_i < COORD_W'(NUM_ROWS * CARD_H));

  assign x_step_c = rem_x_q >= COORD_W'(CARD_W);
  assign y_step_c = rem_y_q >= COORD_W'(CARD_H);
  assign done_c   = active_q && !x_step_c && !y_step_c;
  assign idx_c    = (IDX_W'(row_q) << 4) + (IDX_W'(row_q) << 1) + IDX_W'(col_q);

  always_comb begin
    rem_x_d  = rem_x_q;
    rem_y_d  = rem_y_q;
    col_d    = col_q;
    row_d    = row_q;
    active_d = active_q;
    if (clr_i) begin
      active_d = 1'b0;
    end else if (start_i) begin
      rem_x_d  = dx_i;
      rem_y_d  = dy_i;
      col_d    = '0;
      row_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (done_c) begin
        active_d = 1'b0;
      end
      if (x_step_c) begin
        rem_x_d = rem_x_q - COORD_W'(CARD_W);
        col_d   = col_q + COL_W'(1);
      end
      if (y_step_c) begin
        rem_y_d = rem_y_q - COORD_W'(CARD_H);
        row_d   = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_x_q  <= '0;
      rem_y_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_x_q  <= rem_x_d;
      rem_y_q  <= rem_y_d;
      col_q    <= col_d;
      row_q    <= row_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/map_slot_editor.sv
// Turns mouse clicks into card-slot picks and moves, owning the card map and
// the selection mask shown by the display.
module map_slot_editor
  import card_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interboard_rst,
  input  logic                 en,
  input  logic [COORD_W-1:0]   mouse_x,
  input  logic [COORD_W-1:0]   mouse_y,
  input  logic                 l_click,
  input  logic                 load,
  input  logic [MAP_W-1:0]     load_map,
  output logic [MAP_W-1:0]     map,
  output logic [NUM_SLOTS-1:0] sel_card,
  output logic [IDX_W-1:0]     hit_idx,
  output logic                 busy,
  output logic                 move_done,
  output logic                 move_err
);

  state_e               state_q, state_d;
  logic [MAP_W-1:0]     map_q, map_d;
  logic [NUM_SLOTS-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]     hit_q, hit_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic                 held_q, held_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [COORD_W-1:0]   dx_c, dy_c;
  logic                 in_grid_c, loc_done_c, start_c;
  logic [IDX_W-1:0]     loc_idx_c;
  logic [CODE_W-1:0]    tgt_code_c, src_code_c;
  logic                 tgt_occ_c;

  assign dx_c    = mouse_x - COORD_W'(MAP_X0);
  assign dy_c    = mouse_y - COORD_W'(MAP_Y0);
  assign start_c = (state_q == IDLE) && !interboard_rst && !load &&
                   l_click && en && in_grid_c;

  slot_locator u_locator (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (interboard_rst),
    .start_i   (start_c),
    .dx_i      (dx_c),
    .dy_i      (dy_c),
    .in_grid_c (in_grid_c),
    .done_c    (loc_done_c),
    .idx_c     (loc_idx_c)
  );

  assign tgt_code_c = map_q[slot_lsb(idx_q) +: CODE_W];
  assign src_code_c = map_q[slot_lsb(src_q) +: CODE_W];
  assign tgt_occ_c  = tgt_code_c != EMPTY_CODE;

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    sel_d   = sel_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    src_d   = src_q;
    held_d  = held_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (interboard_rst) begin
      state_d = IDLE;
      map_d   = EMPTY_MAP;
      sel_d   = '0;
      hit_d   = '0;
      idx_d   = '0;
      src_d   = '0;
      held_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            map_d  = load_map;
            sel_d  = '0;
            held_d = 1'b0;
          end else if (start_c) begin
            busy_d  = 1'b1;
            state_d = CALC;
          end else if (!en && held_q) begin
            sel_d[src_q] = 1'b0;
            held_d       = 1'b0;
          end
        end
        CALC: begin
          if (loc_done_c) begin
            idx_d   = loc_idx_c;
            state_d = RESOLVE;
          end
        end
        RESOLVE: begin
          hit_d   = idx_q;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (!held_q) begin
            if (tgt_occ_c) begin
              sel_d[idx_q] = 1'b1;
              src_d        = idx_q;
              held_d       = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (idx_q == src_q) begin
            sel_d[src_q] = 1'b0;
            held_d       = 1'b0;
          end else if (!tgt_occ_c) begin
            map_d[slot_lsb(idx_q) +: CODE_W] = src_code_c;
            map_d[slot_lsb(src_q) +: CODE_W] = EMPTY_CODE;
            sel_d[src_q] = 1'b0;
            held_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            // Clicking another card while holding one switches the pick.
            sel_d[src_q] = 1'b0;
            sel_d[idx_q] = 1'b1;
            src_d        = idx_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      map_q   <= EMPTY_MAP;
      sel_q   <= '0;
      hit_q   <= '0;
      idx_q   <= '0;
      src_q   <= '0;
      held_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      sel_q   <= sel_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign map       = map_q;
  assign sel_card  = sel_q;
  assign hit_idx   = hit_q;
  assign busy      = busy_q;
  assign move_done = done_q;
  assign move_err  = err_q;

endmodule
